mips32_regdump: RTL

Register-file dump engine for the mips32 pipeline. When the core halts, or on an explicit start pulse, it walks the register bank from index 0 to NUM_REGS-1 through a dedicated read port. Each register is emitted as one beat on a valid/ready stream, so test benches and debug links read architectural state through a defined interface instead of peeking into `reg_bank`. It is the read-out counterpart of program loading: it observes the register bank and never writes it.

---
 rtl/mips32_regdump.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mips32_regdump.sv
// Register-file dump engine: on a halted rising edge or a start pulse, walks
// reg_bank index 0..NUM_REGS-1 through a read port and emits one beat per register.
// Latency: trigger at edge T -> rd_en at T+1, rd_data sampled at T+2, out_valid from T+3;
//          3 cycles per register plus stall cycles.
// Backpressure: a beat is held stable in SEND until out_ready; the walk pauses meanwhile.
//
// Ports:
//   clk1, rst              single clock, synchronous active-high reset
//   halted, start          dump triggers (halted rising edge, one-cycle start pulse)
//   rd_en/rd_addr/rd_data  register read port, data returned one cycle after rd_en
//   out_valid/out_ready    beat handshake; out_index/out_data/out_last describe the beat
//   busy, done             dump in progress / dump completed (held until next trigger)
module mips32_regdump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              halted_q;
  logic              trigger;

  // halted_q resets to 0, so halted already high when reset releases counts as
  // a rising edge and starts a dump automatically.
  assign trigger = start | (halted & ~halted_q);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      halted_q  <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      halted_q <= halted;
      // rd_data is valid in the cycle after READ, i.e. during LATCH. Capturing it
      // here keeps every output registered off rd_data and holds the beat stable
      // for as long as SEND stalls.
      if (state == S_LATCH) begin
        out_data  <= rd_data;
        out_index <= idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (trigger) begin
          state_nxt = S_READ;
          idx_nxt   = '0;
        end
      end
      S_READ: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = idx;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        busy      = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          // The walk terminates at the last index instead of wrapping.
          if (idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = S_READ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out_last = out_valid & (out_index == LAST_IDX);

endmodule
